// File: rtl/mode_cfg_seq.sv
// Configuration sequencer: on start, writes NUM_REGS mode-tagged words to the
// test-mode register bank over a valid/ready port, flagging a sticky error on stall timeout.
module mode_cfg_seq #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              user_mode,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, addr_nxt;
    logic [STALL_W-1:0] stall_q, stall_nxt;
    logic               mode_q, mode_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            stall_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            stall_q <= stall_nxt;
            mode_q  <= mode_nxt;
        end
    end

    // Valid/ready: a write transfers on any edge where cfg_valid and cfg_ready are
    // both high; while stalled, addr/data are held and valid only drops on timeout.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        stall_nxt = stall_q;
        mode_nxt  = mode_q;
        case (state)
            WRITE: begin
                if (cfg_ready) begin
                    stall_nxt = '0;
                    if (addr_q == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                    end
                end else if (stall_q >= STALL_LAST) begin
                    // Saturate at TIMEOUT; address is kept for post-mortem debug.
                    stall_nxt = STALL_MAX;
                    state_nxt = ERR;
                end else begin
                    stall_nxt = stall_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_nxt = WRITE;
                    mode_nxt  = user_mode;
                    addr_nxt  = '0;
                    stall_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        cfg_data             = '0;
        cfg_data[DATA_W-1]   = mode_q;
        cfg_data[ADDR_W-1:0] = addr_q;
    end

    assign cfg_valid = (state == WRITE);
    assign busy      = (state == WRITE);
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cfg_addr  = addr_q;

endmodule

// File: doc/mode_cfg_seq.md
# mode_cfg_seq

Configuration sequencer for the test-mode register bank. On `start` it latches the run-mode flag (user mode vs. default mode, as selected by the bench at elapsation from plusargs) and then writes `NUM_REGS` configuration words, addresses 0 to `NUM_REGS-1`, over a valid/ready write port. It reports `busy`, `done`, or a sticky `error` if the bank stalls too long. It sits between the mode-select logic and the register bank so that every test starts from a known, mode-dependent configuration.

## Interface
- `NUM_REGS`, 4: number of config writes per sequence. Range 1 to 2^`ADDR_W`.
- `ADDR_W`, 4: write address width.
- `DATA_W`, 8: write data width. Must be greater than `ADDR_W`.
- `TIMEOUT`, 15: consecutive stalled cycles (`cfg_valid`=1, `cfg_ready`=0) that trigger an error. Must be at least 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a sequence.
- `user_mode`  in  1  mode flag, sampled only in the cycle `start` is accepted.
- `cfg_valid`  out  1  write request valid.
- `cfg_ready`  in  1  register bank accepts the write.
- `cfg_addr`  out  `ADDR_W`  write address.
- `cfg_data`  out  `DATA_W`  write data.
- `busy`  out  1  sequence in progress.
- `done`  out  1  last sequence completed. Held until the next `start` or `rst`.
- `error`  out  1  last sequence aborted on timeout. Sticky until the next `start` or `rst`.

## Operation
- States: IDLE, WRITE, DONE, ERR.
- Reset (`rst`=1 at an edge) moves to IDLE from any state, including mid-sequence. All of the following are 0: `cfg_valid`, `cfg_addr`, `cfg_data`, `busy`, `done`, `error`, the address counter, and the stall counter. No partial write is completed.
- `start` is accepted only in IDLE, DONE or ERR, and moves to WRITE. On acceptance:
  - latch `mode_q` from `user_mode`;
  - set the address counter to 0;
  - clear the stall counter, `done` and `error`.
- `start` while in WRITE is ignored. `user_mode` changes during WRITE have no effect.
- WRITE:
  - `cfg_valid`=1 and `busy`=1.
  - `cfg_addr` = address counter.
  - `cfg_data`: bit `DATA_W-1` = `mode_q`; bits `ADDR_W-1:0` = address counter; all other bits 0.
- Transfer happens on an edge with `cfg_valid` and `cfg_ready` both 1:
  - If the address is not `NUM_REGS-1`, increment the address and clear the stall counter.
  - If the address is `NUM_REGS-1`, go to DONE.
- Stall (`cfg_valid`=1, `cfg_ready`=0): increment the stall counter. When the counter would reach `TIMEOUT`, go to ERR instead.
- DONE: `done`=1; `busy`=0; `cfg_valid`=0.
- ERR: `error`=1; `busy`=0; `cfg_valid`=0. `cfg_addr` holds the stalled address for debug.
- `start` and `rst` in the same cycle: `rst` wins.
- The address counter never wraps. `NUM_REGS`=2^`ADDR_W` ends at the all-ones address.
- The stall counter is wide enough to hold `TIMEOUT` and saturates; it never wraps.

## Timing
- `start` accepted at edge 0 → from edge 0, `cfg_valid`=1 with `cfg_addr`=0 and `busy`=1. Latency from start to first request is 1 cycle.
- Throughput: 1 write per cycle with `cfg_ready` held at 1. No bubble between addresses: `cfg_valid` stays high across transfers.
- Stall stability: while `cfg_valid`=1 and `cfg_ready`=0, `cfg_addr` and `cfg_data` must stay constant. `cfg_valid` never deasserts without a transfer, except on timeout or `rst`.
- Completion: the last transfer at edge N → from edge N, `done`=1, `busy`=0, `cfg_valid`=0.
  - `NUM_REGS`=4 with no stalls: start at edge 0, transfers at edges 1 to 4, `done` visible after edge 4.
- Timeout: after `TIMEOUT` consecutive stalled edges, `error`=1 and `cfg_valid`=0 are visible from that edge on.
  - A transfer at any point restarts the count.
  - `cfg_ready` rising on the same edge that the count reaches `TIMEOUT`: the transfer wins, and there is no error.
- `done` and `error` are mutually exclusive. Both clear on the edge that accepts the next `start`.

## Test plan
- Reset value: assert `rst` for 2 cycles → every output is 0 and the state is IDLE. Pulse `start` during `rst` → nothing happens.
- Default mode, no stalls: `NUM_REGS`=4, `user_mode`=0, `cfg_ready`=1 → writes addr/data 0/0x00, 1/0x01, 2/0x02, 3/0x03 on 4 consecutive cycles, then `done`=1 and `busy`=0.
- User mode with stalls: `user_mode`=1 at start, then toggle `user_mode` mid-run; `cfg_ready` low for 3 cycles on address 2 → data stays 0x82 throughout the stall, all data has bit 7 set, and the sequence completes with `done`=1.
- Timeout: `cfg_ready` held at 0 → after 15 stalled cycles at address 0, `error`=1, `cfg_valid`=0, `cfg_addr`=0. A new `start` with ready=1 clears `error` and completes normally.
- Boundaries:
  - ready rises on stall cycle 15 → no error;
  - `start` pulse during WRITE → ignored;
  - `rst` asserted at address 2 → all outputs 0 and IDLE next cycle.
- Back-to-back: `start` in the cycle after `done` → `done` clears and the sequence restarts at address 0 with the new `user_mode`.
